// File: rtl/vga_plot_arbiter_pkg.sv
// vga_pkg: shared VGA geometry constants and arbiter state encoding
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOR_W = 3;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;
endpackage

// File: rtl/vga_plot_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request at or above ptr with wrap
module rr_pick #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);
  logic [PW:0] s;
  // scan downward so the lowest offset from ptr is written last and wins
  always_comb begin
    pick = '0;
    s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      s = (s >= (PW+1)'(N)) ? s - (PW+1)'(N) : s;
      if (req[s[PW-1:0]]) pick = N'(1) << s[PW-1:0];
    end
  end
  assign valid = |req;
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: round-robin sharing of the VGA pixel-write port with burst limits
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int MAX_BURST = 16,
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ-1:0]         Lock,
  input  logic [NREQ*X_W-1:0]     XIn,
  input  logic [NREQ*Y_W-1:0]     YIn,
  input  logic [NREQ*COLOR_W-1:0] ColorIn,
  output logic [NREQ-1:0]         Grant,
  output logic [X_W-1:0]          X,
  output logic [Y_W-1:0]          Y,
  output logic [COLOR_W-1:0]      Color,
  output logic                    Plot,
  output logic                    Busy,
  output logic                    Clipped
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  state_t state;
  logic [PW-1:0] ptr, gidx, pick_idx;
  logic [CW-1:0] cnt;
  logic lock_q;
  logic [NREQ-1:0] pick;
  logic valid;
  logic [X_W-1:0] xs [NREQ];
  logic [Y_W-1:0] ys [NREQ];
  logic [COLOR_W-1:0] cs [NREQ];
  logic acc, in_range, at_limit;
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign xs[i] = XIn[i*X_W +: X_W];
    assign ys[i] = YIn[i*Y_W +: Y_W];
    assign cs[i] = ColorIn[i*COLOR_W +: COLOR_W];
  end
  rr_pick #(.N(NREQ)) u_pick (
    .req(Req),
    .ptr(ptr),
    .pick(pick),
    .valid(valid)
  );
  // one-hot pick to index
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) pick_idx = pick[i] ? PW'(i) : pick_idx;
  end
  assign acc = |(Grant & Req);
  assign in_range = (xs[gidx] < X_W'(SCREEN_W)) && (ys[gidx] < Y_W'(SCREEN_H));
  assign at_limit = !lock_q && (cnt == CW'(MAX_BURST - 1));
  // arbiter FSM with registered grant and pixel outputs
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      ptr <= '0;
      gidx <= '0;
      cnt <= '0;
      lock_q <= 1'b0;
      Grant <= '0;
      X <= '0;
      Y <= '0;
      Color <= '0;
      Plot <= 1'b0;
      Busy <= 1'b0;
      Clipped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Plot <= 1'b0;
          if (valid) begin
            Grant <= pick;
            Busy <= 1'b1;
            lock_q <= |(Lock & pick);
            gidx <= pick_idx;
            state <= GRANT;
          end
        end
        GRANT: begin
          Plot <= acc && in_range;
          if (acc && in_range) begin
            X <= xs[gidx];
            Y <= ys[gidx];
            Color <= cs[gidx];
          end
          if (acc && !in_range) Clipped <= 1'b1;
          if (acc) cnt <= cnt + 1'b1;
          if (!acc || at_limit) begin
            Grant <= '0;
            Busy <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          Plot <= 1'b0;
          ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
